// File: rtl/impulse_ctrl_pkg.sv
// rtl/impulse_ctrl_pkg.sv - shared types and BCD constants for the gated impulse counter
package impulse_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, GATE, HOLD} state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Non-decimal nibbles are loaded as zero so a digit never holds a value above 9.
    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MIN : v;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD up/down digit with load and terminal-value flags
module bcd_digit_cell
    import impulse_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [BCD_W-1:0] LOAD_VAL,
    input  logic             EN,
    input  logic             DIR,
    output logic [BCD_W-1:0] Q,
    output logic             AT_MAX,
    output logic             AT_MIN
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (LOAD) begin
            Q <= bcd_sanitize(LOAD_VAL);
        end else if (EN) begin
            if (DIR)
                Q <= (Q == BCD_MAX) ? BCD_MIN : Q + 4'd1;
            else
                Q <= (Q == BCD_MIN) ? BCD_MAX : Q - 4'd1;
        end
    end

    assign AT_MAX = (Q == BCD_MAX);
    assign AT_MIN = (Q == BCD_MIN);

endmodule

// File: rtl/impulse_gate_ctrl.sv
// rtl/impulse_gate_ctrl.sv - CLEAR/GATE/HOLD sequencer driving a cascade of BCD digit cells
module impulse_gate_ctrl
    import impulse_ctrl_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int GATE_CYCLES = 1000,
    parameter int HOLD_CYCLES = 100
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    DIR_SEL,
    input  logic [4*DIGITS-1:0]     PRESET_BCD,
    input  logic                    PULSE_IN,
    output logic [4*DIGITS-1:0]     COUNT_BCD,
    output logic [4*DIGITS-1:0]     RESULT_BCD,
    output logic                    RESULT_OVF,
    output logic                    RESULT_VALID,
    output logic                    BUSY
);

    localparam int MAX_CYC = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    state_t            state;
    logic [TW-1:0]     timer;
    logic              s1, s2, s3;
    logic              evt;
    logic              dir_q;
    logic              ovf_q;
    logic              load;
    logic              carry;
    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;

    assign evt  = s2 & ~s3;
    assign load = (state == CLEAR);

    // Ripple enable: a digit steps only when every lower digit is about to wrap.
    always_comb begin
        en    = '0;
        carry = evt && (state == GATE);
        for (int i = 0; i < DIGITS; i++) begin
            en[i] = carry;
            carry = carry & (dir_q ? at_max[i] : at_min[i]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_digit (
            .CLK      (CLK),
            .RST      (RST),
            .LOAD     (load),
            .LOAD_VAL (PRESET_BCD[g*BCD_W +: BCD_W]),
            .EN       (en[g]),
            .DIR      (dir_q),
            .Q        (COUNT_BCD[g*BCD_W +: BCD_W]),
            .AT_MAX   (at_max[g]),
            .AT_MIN   (at_min[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            timer        <= '0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            dir_q        <= 1'b0;
            ovf_q        <= 1'b0;
            RESULT_BCD   <= '0;
            RESULT_OVF   <= 1'b0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            s1           <= PULSE_IN;
            s2           <= s1;
            s3           <= s2;
            RESULT_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= CLEAR;
                        BUSY  <= 1'b1;
                    end
                end
                CLEAR: begin
                    dir_q <= DIR_SEL;
                    ovf_q <= 1'b0;
                    timer <= GATE_LOAD;
                    state <= GATE;
                end
                GATE: begin
                    if (carry)
                        ovf_q <= 1'b1;
                    if (timer == '0) begin
                        state <= HOLD;
                        timer <= HOLD_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer == HOLD_LOAD) begin
                        RESULT_BCD   <= COUNT_BCD;
                        RESULT_OVF   <= ovf_q;
                        RESULT_VALID <= 1'b1;
                    end
                    if (timer == '0) begin
                        if (START) begin
                            state <= CLEAR;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impulse_gate_ctrl.sv
// tb/tb_impulse_gate_ctrl.sv - directed bench with a window-position model of the impulse counter
module tb_impulse_gate_ctrl;

    localparam int D    = 2;
    localparam int G    = 20;
    localparam int H    = 4;
    localparam int MODV = 100;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           START = 1'b0;
    logic           DIR_SEL = 1'b1;
    logic [4*D-1:0] PRESET_BCD = '0;
    logic           PULSE_IN = 1'b0;
    logic [4*D-1:0] COUNT_BCD;
    logic [4*D-1:0] RESULT_BCD;
    logic           RESULT_OVF;
    logic           RESULT_VALID;
    logic           BUSY;

    impulse_gate_ctrl #(.DIGITS(D), .GATE_CYCLES(G), .HOLD_CYCLES(H)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .DIR_SEL      (DIR_SEL),
        .PRESET_BCD   (PRESET_BCD),
        .PULSE_IN     (PULSE_IN),
        .COUNT_BCD    (COUNT_BCD),
        .RESULT_BCD   (RESULT_BCD),
        .RESULT_OVF   (RESULT_OVF),
        .RESULT_VALID (RESULT_VALID),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: decimal value plus position within the window (-1 idle, 0 clear, 1..G gate, G+1..G+H hold).
    int   m_val = 0, m_dir = 0, m_ovf = 0, m_wpos = -1;
    int   m_res = 0, m_resovf = 0, m_valid = 0;
    bit   m_ready = 0;
    bit   m_evt;
    bit   samp [3];

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_preset(input logic [4*D-1:0] p);
        int v = 0, scale = 1;
        logic [3:0] nib;
        for (int i = 0; i < D; i++) begin
            nib = p[4*i +: 4];
            if (nib <= 4'd9) v += int'(nib) * scale;
            scale *= 10;
        end
        return v;
    endfunction

    task automatic model_step();
        if (RST) begin
            m_ready = 1; m_val = 0; m_ovf = 0; m_dir = 0; m_wpos = -1;
            m_res = 0; m_resovf = 0; m_valid = 0;
            samp[0] = 0; samp[1] = 0; samp[2] = 0;
        end else begin
            m_evt   = samp[1] && !samp[2];
            m_valid = 0;
            if (m_wpos == -1) begin
                if (START) m_wpos = 0;
            end else if (m_wpos == 0) begin
                m_val = from_preset(PRESET_BCD); m_dir = int'(DIR_SEL); m_ovf = 0; m_wpos = 1;
            end else if (m_wpos <= G) begin
                if (m_evt) begin
                    if (m_dir != 0) begin
                        if (m_val == MODV - 1) m_ovf = 1;
                        m_val = (m_val + 1) % MODV;
                    end else begin
                        if (m_val == 0) m_ovf = 1;
                        m_val = (m_val + MODV - 1) % MODV;
                    end
                end
                m_wpos++;
            end else begin
                if (m_wpos == G + 1) begin
                    m_res = m_val; m_resovf = m_ovf; m_valid = 1;
                end
                if (m_wpos == G + H) m_wpos = START ? 0 : -1;
                else m_wpos++;
            end
            samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = PULSE_IN;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (m_ready) begin
            check("count",  COUNT_BCD,    to_bcd(m_val));
            check("result", RESULT_BCD,   to_bcd(m_res));
            check("ovf",    RESULT_OVF,   m_resovf[0]);
            check("valid",  RESULT_VALID, m_valid[0]);
            check("busy",   BUSY,         (m_wpos != -1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (m_wpos != p && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (m_wpos != p) begin
            total_cnt++;
            $display("FAIL wait_pos: window position %0d never reached (at %0d)", p, m_wpos);
        end
    endtask

    task automatic pulse();
        PULSE_IN = 1'b1; tick(2);
        PULSE_IN = 1'b0; tick(2);
    endtask

    task automatic wait_result(input string name, input logic [7:0] exp_bcd, input logic exp_ovf);
        int k = 0;
        while (RESULT_VALID !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check({name, "_valid"}, RESULT_VALID, 1);
        check({name, "_bcd"},   RESULT_BCD,   exp_bcd);
        check({name, "_ovf"},   RESULT_OVF,   exp_ovf);
        tick(1);
        check({name, "_valid_1cyc"}, RESULT_VALID, 0);
    endtask

    task automatic run_window(input string name, input logic [7:0] preset, input logic dir,
                              input int n, input logic [7:0] exp_bcd, input logic exp_ovf);
        PRESET_BCD = preset; DIR_SEL = dir; START = 1'b1;
        wait_pos(1);
        START = 1'b0;
        repeat (n) pulse();
        wait_result(name, exp_bcd, exp_ovf);
        wait_pos(-1);
        check({name, "_idle_busy"}, BUSY, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_count",  COUNT_BCD,    0);
        check("rst_result", RESULT_BCD,   0);
        check("rst_valid",  RESULT_VALID, 0);
        check("rst_busy",   BUSY,         0);
        RST = 1'b0;
        tick(2);

        run_window("up5",    8'h00, 1'b1, 5, 8'h05, 1'b0);
        run_window("carry",  8'h09, 1'b1, 1, 8'h10, 1'b0);
        run_window("wrapup", 8'h98, 1'b1, 3, 8'h01, 1'b1);
        run_window("borrow", 8'h10, 1'b0, 1, 8'h09, 1'b0);
        run_window("wrapdn", 8'h00, 1'b0, 1, 8'h99, 1'b1);

        // Pulse whose event lands in the final GATE cycle.
        PRESET_BCD = 8'h00; DIR_SEL = 1'b1; START = 1'b1;
        wait_pos(G - 2); START = 1'b0;
        PULSE_IN = 1'b1; tick(2); PULSE_IN = 1'b0;
        wait_result("last_gate", 8'h01, 1'b0);
        wait_pos(-1);

        // Pulse whose event lands in the first HOLD cycle.
        START = 1'b1;
        wait_pos(G - 1); START = 1'b0;
        PULSE_IN = 1'b1; tick(2); PULSE_IN = 1'b0;
        wait_result("first_hold", 8'h00, 1'b0);
        wait_pos(-1);

        // Latency: rise sampled at edge k, count changes at edge k+2.
        START = 1'b1;
        wait_pos(5); START = 1'b0;
        PULSE_IN = 1'b1; tick(2);
        check("lat_k1", COUNT_BCD, 8'h00);
        PULSE_IN = 1'b0; tick(1);
        check("lat_k2", COUNT_BCD, 8'h01);
        wait_result("latency", 8'h01, 1'b0);
        wait_pos(-1);

        pulse(); pulse();
        check("idle_pulses", COUNT_BCD, 8'h01);

        // Back-to-back windows, preset reloaded; DIR toggle and START drop mid-GATE.
        PRESET_BCD = 8'h05; DIR_SEL = 1'b1; START = 1'b1;
        wait_pos(1);
        pulse();
        wait_result("b2b_w1", 8'h06, 1'b0);
        wait_pos(0);
        check("b2b_busy", BUSY, 1);
        wait_pos(1);
        pulse();
        DIR_SEL = 1'b0; START = 1'b0;
        pulse();
        wait_result("b2b_w2", 8'h07, 1'b0);
        wait_pos(-1);
        check("stop_busy", BUSY, 0);

        // Reset mid-GATE.
        PRESET_BCD = 8'h35; DIR_SEL = 1'b1; START = 1'b1;
        wait_pos(1); START = 1'b0;
        pulse(); pulse();
        check("pre_rst_count", COUNT_BCD, 8'h37);
        RST = 1'b1; tick(1);
        check("rst_mid_count",  COUNT_BCD,    0);
        check("rst_mid_result", RESULT_BCD,   0);
        check("rst_mid_ovf",    RESULT_OVF,   0);
        check("rst_mid_valid",  RESULT_VALID, 0);
        check("rst_mid_busy",   BUSY,         0);
        RST = 1'b0;
        tick(G + H + 4);
        check("rst_no_result", RESULT_BCD, 0);

        run_window("illegal", 8'hFA, 1'b1, 0, 8'h00, 1'b0);

        tick(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
